fb_scanout: RTL and testbench
=============================

Name: fb_scanout

Overview:
- Frame-buffer reader on the far side of the z-buffer: zbuffer writes (pixel_addr, pixel_out) into a SIZE x SIZE pixel BRAM; fb_scanout reads it back in raster order.
- Streams each pixel with its x/y coordinate to the display/compositor over a valid/ready interface.
- Absorbs fixed BRAM read latency with a credit-controlled skid FIFO, so downstream backpressure never drops or duplicates a pixel.

Parameters:
- SIZE, 64, frame edge in pixels; power of two.
- PIX_W, 10, pixel data width; matches zbuffer pixel_out.
- ADDR_W, 12, BRAM address width; SIZE*SIZE <= 2**ADDR_W.
- RD_LAT, 2, BRAM read latency in cycles, 1..4.
- CLEAR_VAL, 0, PIX_W-bit value written back by the optional clear feature.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-low (rst==0 resets).
- start  in  1  single-cycle frame-start pulse; honoured only in IDLE.
- busy  out  1  high in SCAN or DRAIN.
- rd_addr  out  ADDR_W  BRAM read address.
- rd_en  out  1  BRAM read strobe.
- rd_data  in  PIX_W  BRAM read data, valid RD_LAT cycles after rd_en.
- wr_en  out  1  clear write strobe (optional feature).
- wr_addr  out  ADDR_W  clear write address.
- wr_data  out  PIX_W  clear write data.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_pixel  out  PIX_W  pixel value.
- m_x  out  log2(SIZE)  column.
- m_y  out  log2(SIZE)  row.
- m_last  out  1  high on the beat for address SIZE*SIZE-1.
- frame_done  out  1  one-cycle pulse when the frame has fully drained.

Behaviour:
- Reset (rst==0 at a clock edge):
  - State=IDLE; busy, rd_en, wr_en, m_valid, m_last and frame_done all 0.
  - rd_addr, wr_addr, m_pixel, m_x and m_y all 0.
  - FIFO emptied and outstanding-read counter cleared.
  - Reset mid-frame aborts the frame immediately. In-flight BRAM returns after reset are ignored. No frame_done is issued.
- States:
  - IDLE: on start=1, go to SCAN with read pointer rp=0.
  - SCAN: issue reads. After the read of SIZE*SIZE-1 is issued, go to DRAIN.
  - DRAIN: wait until outstanding==0 and the FIFO is empty. Then pulse frame_done for one cycle and return to IDLE.
  - start outside IDLE is ignored. start in the same cycle as frame_done is ignored.
- Read issue (credit rule):
  - Skid FIFO depth is RD_LAT+2.
  - A read issues in a SCAN cycle only when occupancy + outstanding < RD_LAT+2, counting the pop of the same cycle.
  - On issue: rd_en=1, rd_addr=rp, rp increments.
  - Each return is pushed into the FIFO together with its address. The FIFO can never overflow.
- Latency:
  - start sampled at edge k; first rd_en in cycle k+1.
  - rd_data pushed at cycle k+1+RD_LAT.
  - m_valid=1 from cycle k+2+RD_LAT (registered FIFO head).
- Throughput: with m_ready held at 1, one beat per cycle, with no bubbles after the first.
- Output handshake:
  - A beat transfers when m_valid && m_ready.
  - While m_valid=1 && m_ready=0, m_pixel, m_x, m_y and m_last hold stable.
  - m_valid never drops without a transfer.
- Coordinates: m_x = addr[log2(SIZE)-1:0]; m_y = addr[2*log2(SIZE)-1:log2(SIZE)]. Row-major, x fastest.
- m_last is asserted only with the beat for address SIZE*SIZE-1.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- Simultaneous push and pop on an empty FIFO: the pushed data reaches the head next cycle. There is no combinational bypass.

Optional Feature:
- Macro: FB_SCANOUT_CLEAR_ON_READ_EN.
- Defined:
  - In the cycle a read for address A returns, wr_en=1, wr_addr=A and wr_data=CLEAR_VAL.
  - This leaves the frame buffer cleared for the next zbuffer pass.
  - Writes follow reads, so no address is written before it is read.
- Undefined: wr_en is tied 0, and wr_addr and wr_data are tied 0.

Test Plan:
- Full throughput: BRAM model with pixel = addr[9:0], m_ready=1, pulse start. Required:
  - first m_valid at start+RD_LAT+2 cycles (4 at default);
  - 4096 consecutive beats, beat n has m_pixel=n%1024, m_x=n%64, m_y=n/64;
  - m_last only on beat 4095 (x=63, y=63);
  - frame_done exactly one cycle after the last transfer.
- Backpressure: m_ready toggles via a pseudo-random 50% pattern, and is held at 0 for 20 cycles. Required:
  - no lost or duplicated addresses;
  - outputs stable while stalled;
  - outstanding+occupancy never exceeds 4.
- Start while busy: pulse start again at beat 100. Required: no restart, exactly 4096 beats, one frame_done.
- Reset mid-frame: drive rst=0 for one cycle at beat 2000. Required:
  - next cycle m_valid=0, busy=0 and no frame_done;
  - a new start yields beats from addr 0 again.
- Clear-on-read (macro defined): after a frame, read every BRAM word. Required:
  - all words equal CLEAR_VAL=0;
  - wr_addr sequence is 0..4095, each write in the same cycle as the matching return.
- Macro undefined: same stimulus as the clear-on-read scenario. Required: wr_en never 1, and BRAM contents are unchanged.

Source files
------------

// File: rtl/fb_scanout_if.sv
// Pixel stream interface between fb_scanout and the display/compositor.
// master drives the beat, slave returns m_ready.
interface fb_scanout_if #(
    parameter int PIX_W = 10,
    parameter int XY_W  = 6
);
    logic             m_valid;
    logic             m_ready;
    logic [PIX_W-1:0] m_pixel;
    logic [XY_W-1:0]  m_x;
    logic [XY_W-1:0]  m_y;
    logic             m_last;

    modport master (
        output m_valid, m_pixel, m_x, m_y, m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_pixel, m_x, m_y, m_last,
        output m_ready
    );
endinterface

// File: rtl/fb_scanout.sv
// Raster-order frame-buffer reader with credit-controlled skid FIFO.
// Optional clear-on-read write-back enabled by FB_SCANOUT_CLEAR_ON_READ_EN.
module fb_scanout #(
    parameter int               SIZE      = 64,
    parameter int               PIX_W     = 10,
    parameter int               ADDR_W    = 12,
    parameter int               RD_LAT    = 2,
    parameter logic [PIX_W-1:0] CLEAR_VAL = {PIX_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    fb_scanout_if.master      m,
    output logic              frame_done
);

    localparam int XY_W   = $clog2(SIZE);
    localparam int DEPTH  = RD_LAT + 2;
    // The output register holds the head entry; the array holds the rest.
    localparam int IDEPTH = RD_LAT + 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(IDEPTH);
    localparam int TOT_W  = CNT_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE * SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(IDEPTH - 1)) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1'b1);
        end
        return n;
    endfunction

    state_t            state_r;
    state_t            state_s;
    logic              busy_r;
    logic              frame_done_r;
    logic [ADDR_W-1:0] rp_r;
    logic              rd_en_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic [CNT_W-1:0]  out_r;

    logic              ret_vld_r  [RD_LAT];
    logic [ADDR_W-1:0] ret_addr_r [RD_LAT];

    logic [PIX_W-1:0]  fifo_pix_r  [IDEPTH];
    logic [ADDR_W-1:0] fifo_addr_r [IDEPTH];
    logic [PTR_W-1:0]  wptr_r;
    logic [PTR_W-1:0]  rptr_r;
    logic [CNT_W-1:0]  icnt_r;

    logic              m_valid_r;
    logic [PIX_W-1:0]  m_pixel_r;
    logic [XY_W-1:0]   m_x_r;
    logic [XY_W-1:0]   m_y_r;
    logic              m_last_r;

    logic              issue_s;
    logic              done_s;
    logic              push_s;
    logic [ADDR_W-1:0] push_addr_s;
    logic              pop_s;
    logic              out_free_s;
    logic              ipush_s;
    logic              ipop_s;
    logic              head_load_s;
    logic [PIX_W-1:0]  head_pix_s;
    logic [ADDR_W-1:0] head_addr_s;
    logic [TOT_W-1:0]  occ_s;
    logic              credit_s;
    logic              drain_empty_s;

    // FIFO occupancy, credit check and head-load selection.
    always_comb begin
        push_s        = ret_vld_r[RD_LAT-1];
        push_addr_s   = ret_addr_r[RD_LAT-1];
        pop_s         = m_valid_r && m.m_ready;
        out_free_s    = !m_valid_r || pop_s;
        occ_s         = TOT_W'(m_valid_r) + TOT_W'(icnt_r);
        credit_s      = (occ_s + TOT_W'(out_r)) < (TOT_W'(DEPTH) + TOT_W'(pop_s));
        drain_empty_s = (TOT_W'(out_r) == TOT_W'(push_s)) &&
                        ((occ_s + TOT_W'(push_s)) == TOT_W'(pop_s));
        ipop_s        = out_free_s && (icnt_r != {CNT_W{1'b0}});
        ipush_s       = push_s && !(out_free_s && (icnt_r == {CNT_W{1'b0}}));
        head_load_s   = out_free_s && ((icnt_r != {CNT_W{1'b0}}) || push_s);
        if (icnt_r != {CNT_W{1'b0}}) begin
            head_pix_s  = fifo_pix_r[rptr_r];
            head_addr_s = fifo_addr_r[rptr_r];
        end else begin
            head_pix_s  = rd_data;
            head_addr_s = push_addr_s;
        end
    end

    // Next-state and read-issue decision; a start coinciding with frame_done is dropped.
    always_comb begin
        state_s = state_r;
        issue_s = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !frame_done_r) begin
                    issue_s = credit_s;
                    state_s = ST_SCAN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (credit_s) begin
                    issue_s = 1'b1;
                    if (rp_r == LAST_ADDR) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_SCAN;
                    end
                end else begin
                    state_s = ST_SCAN;
                end
            end
            ST_DRAIN: begin
                if (drain_empty_s) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control state, read port and outstanding-read counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            rp_r         <= {ADDR_W{1'b0}};
            rd_en_r      <= 1'b0;
            rd_addr_r    <= {ADDR_W{1'b0}};
            out_r        <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_s;
            busy_r       <= (state_s != ST_IDLE);
            frame_done_r <= done_s;
            rd_en_r      <= issue_s;
            out_r        <= out_r + CNT_W'(issue_s) - CNT_W'(push_s);
            if (issue_s) begin
                rd_addr_r <= rp_r;
                if (state_s == ST_DRAIN) begin
                    rp_r <= {ADDR_W{1'b0}};
                end else begin
                    rp_r <= rp_r + ADDR_W'(1'b1);
                end
            end
        end
    end

    // Tracks which issued reads return in which cycle; cleared on reset so stale returns vanish.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                ret_vld_r[i]  <= 1'b0;
                ret_addr_r[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            ret_vld_r[0]  <= rd_en_r;
            ret_addr_r[0] <= rd_addr_r;
            for (int i = 1; i < RD_LAT; i++) begin
                ret_vld_r[i]  <= ret_vld_r[i-1];
                ret_addr_r[i] <= ret_addr_r[i-1];
            end
        end
    end

    // Skid storage behind the output register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < IDEPTH; i++) begin
                fifo_pix_r[i]  <= {PIX_W{1'b0}};
                fifo_addr_r[i] <= {ADDR_W{1'b0}};
            end
            wptr_r <= {PTR_W{1'b0}};
            rptr_r <= {PTR_W{1'b0}};
            icnt_r <= {CNT_W{1'b0}};
        end else begin
            if (ipush_s) begin
                fifo_pix_r[wptr_r]  <= rd_data;
                fifo_addr_r[wptr_r] <= push_addr_s;
                wptr_r              <= ptr_inc(wptr_r);
            end
            if (ipop_s) begin
                rptr_r <= ptr_inc(rptr_r);
            end
            icnt_r <= icnt_r + CNT_W'(ipush_s) - CNT_W'(ipop_s);
        end
    end

    // Output beat register; only reloads once the current beat has been accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_valid_r <= 1'b0;
            m_pixel_r <= {PIX_W{1'b0}};
            m_x_r     <= {XY_W{1'b0}};
            m_y_r     <= {XY_W{1'b0}};
            m_last_r  <= 1'b0;
        end else if (head_load_s) begin
            m_valid_r <= 1'b1;
            m_pixel_r <= head_pix_s;
            m_x_r     <= head_addr_s[XY_W-1:0];
            m_y_r     <= head_addr_s[2*XY_W-1:XY_W];
            m_last_r  <= (head_addr_s == LAST_ADDR);
        end else if (out_free_s) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end else begin
            m_valid_r <= m_valid_r;
        end
    end

    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign rd_en      = rd_en_r;
    assign rd_addr    = rd_addr_r;
    assign m.m_valid  = m_valid_r;
    assign m.m_pixel  = m_pixel_r;
    assign m.m_x      = m_x_r;
    assign m.m_y      = m_y_r;
    assign m.m_last   = m_last_r;

`ifdef FB_SCANOUT_CLEAR_ON_READ_EN
    assign wr_en   = push_s;
    assign wr_addr = push_addr_s;
    assign wr_data = CLEAR_VAL;
`else
    assign wr_en   = 1'b0;
    assign wr_addr = {ADDR_W{1'b0}};
    // Keeps CLEAR_VAL referenced in builds without the write-back path.
    assign wr_data = CLEAR_VAL & {PIX_W{1'b0}};
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout: scenario table plus hand-written reset and clear sequences.
module tb_fb_scanout;
    localparam int SIZE   = 64;
    localparam int PIX_W  = 10;
    localparam int ADDR_W = 12;
    localparam int RD_LAT = 2;
    localparam int NPIX   = SIZE * SIZE;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [PIX_W-1:0]  rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              frame_done;

    always #5 clk = ~clk;

    fb_scanout_if #(.PIX_W(PIX_W), .XY_W(6)) s_if ();

    fb_scanout #(
        .SIZE(SIZE), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .CLEAR_VAL(10'd0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .m(s_if), .frame_done(frame_done)
    );

    // BRAM model: two-cycle read latency, write port, bulk fill with pixel = addr[9:0].
    logic [PIX_W-1:0]  mem [NPIX];
    logic [PIX_W-1:0]  p1;
    logic              rv1, rv2;
    logic [ADDR_W-1:0] ra1, ra2;
    logic              fill_req;
    int                cyc = 0;

    always @(posedge clk) begin
        p1      <= mem[rd_addr];
        rd_data <= p1;
        rv1     <= rd_en;
        rv2     <= rv1;
        ra1     <= rd_addr;
        ra2     <= ra1;
        cyc     <= cyc + 1;
        if (fill_req) begin
            for (int i = 0; i < NPIX; i++) mem[i] <= PIX_W'(i);
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor state
    bit  mon_en = 1'b0;
    int  beats, issued, dones, last_xfer_cyc, first_valid_cyc, start_cyc, wr_seq;
    bit  wr_seen, stall_prev;
    int  held;

    task automatic mon_clear();
        beats = 0; issued = 0; dones = 0; last_xfer_cyc = -10; first_valid_cyc = -1;
        wr_seq = 0; wr_seen = 1'b0; stall_prev = 1'b0; held = 0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (cyc == start_cyc + 1) begin
                    check("first_rd_en", int'(rd_en), 1);
                    check("first_rd_addr", int'(rd_addr), 0);
                end
                if (first_valid_cyc < 0 && s_if.m_valid) first_valid_cyc = cyc;
                if (stall_prev) begin
                    check("stall_valid_held", int'(s_if.m_valid), 1);
                    check("stall_data_held",
                          int'({s_if.m_pixel, s_if.m_x, s_if.m_y, s_if.m_last}), held);
                end
                if (rd_en) begin
                    issued++;
                    check("credit_outstanding_le4", (issued - beats > 4) ? issued - beats : 0, 0);
                end
                if (frame_done) begin
                    dones++;
                    check("done_one_after_last", cyc, last_xfer_cyc + 1);
                    check("done_beats", beats, NPIX);
                end
                if (s_if.m_valid && s_if.m_ready) begin
                    check("beat_pixel", int'(s_if.m_pixel), beats % 1024);
                    check("beat_x", int'(s_if.m_x), beats % SIZE);
                    check("beat_y", int'(s_if.m_y), (beats / SIZE) % SIZE);
                    check("beat_last", int'(s_if.m_last), (beats == NPIX - 1) ? 1 : 0);
                    beats++;
                    last_xfer_cyc = cyc;
                end
                stall_prev = s_if.m_valid && !s_if.m_ready;
                held = int'({s_if.m_pixel, s_if.m_x, s_if.m_y, s_if.m_last});
`ifdef FB_SCANOUT_CLEAR_ON_READ_EN
                if (wr_en || rv2) begin
                    check("wr_with_return", int'(wr_en), int'(rv2));
                    check("wr_addr_return", int'(wr_addr), int'(ra2));
                    check("wr_addr_seq", int'(wr_addr), wr_seq);
                    check("wr_data_clear", int'(wr_data), 0);
                    wr_seq++;
                end
`else
                if (wr_en) wr_seen = 1'b1;
`endif
            end
        end
    end

    typedef struct {
        bit rnd_ready;
        int stall_beat;
        int restart_beat;
        bit start_on_done;
        int exp_beats;
        int exp_dones;
        int exp_lat;
    } vec_t;

    vec_t vecs [4];

    task automatic fill_bram();
        @(posedge clk); #1 fill_req = 1'b1;
        @(posedge clk); #1 fill_req = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int  post;
        int  stall_cnt;
        bit  stalled;
        bit  restarted;
        post = 0; stall_cnt = 0; stalled = 1'b0; restarted = 1'b0;
        fill_bram();
        mon_clear();
        start_cyc   = cyc;
        mon_en      = 1'b1;
        start       = 1'b1;
        s_if.m_ready = 1'b1;
        for (int n = 0; n < 40000; n++) begin
            if (dones > 0 && post >= 12) break;
            @(posedge clk); #1;
            start = 1'b0;
            if (dones > 0) post++;
            if (v.restart_beat >= 0 && !restarted && beats >= v.restart_beat) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            if (v.start_on_done && frame_done) start = 1'b1;
            if (v.stall_beat >= 0 && !stalled && beats >= v.stall_beat) begin
                stalled = 1'b1;
                stall_cnt = 20;
            end
            if (stall_cnt > 0) begin
                s_if.m_ready = 1'b0;
                stall_cnt--;
            end else if (v.rnd_ready) begin
                s_if.m_ready = 1'($urandom_range(1, 0));
            end else begin
                s_if.m_ready = 1'b1;
            end
        end
        check("frame_beats", beats, v.exp_beats);
        check("frame_dones", dones, v.exp_dones);
        check("first_valid_latency", first_valid_cyc - start_cyc, v.exp_lat);
        check("busy_after_frame", int'(busy), 0);
`ifdef FB_SCANOUT_CLEAR_ON_READ_EN
        check("wr_count", wr_seq, NPIX);
`else
        check("wr_en_never", int'(wr_seen), 0);
`endif
        mon_en = 1'b0;
        s_if.m_ready = 1'b1;
    endtask

    initial begin
        // rnd, stall_beat, restart_beat, start_on_done, beats, dones, latency
        vecs[0] = '{1'b0, -1,  -1, 1'b0, NPIX, 1, RD_LAT + 2};
        vecs[1] = '{1'b1, 300, -1, 1'b0, NPIX, 1, RD_LAT + 2};
        vecs[2] = '{1'b0, -1, 100, 1'b0, NPIX, 1, RD_LAT + 2};
        vecs[3] = '{1'b0, -1,  -1, 1'b1, NPIX, 1, RD_LAT + 2};

        rst = 1'b0; start = 1'b0; s_if.m_ready = 1'b1; fill_req = 1'b1;
        repeat (3) @(posedge clk);
        #1 fill_req = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_rd_en", int'(rd_en), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_m_valid", int'(s_if.m_valid), 0);
        check("rst_m_last", int'(s_if.m_last), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_rd_addr", int'(rd_addr), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_m_pixel", int'(s_if.m_pixel), 0);
        check("rst_m_x", int'(s_if.m_x), 0);
        check("rst_m_y", int'(s_if.m_y), 0);
        @(posedge clk); #1 rst = 1'b1;

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Frame buffer contents after the last complete frame
        for (int i = 0; i < NPIX; i++) begin
`ifdef FB_SCANOUT_CLEAR_ON_READ_EN
            check("bram_cleared", int'(mem[i]), 0);
`else
            check("bram_unchanged", int'(mem[i]), i % 1024);
`endif
        end

        // Reset in the middle of a frame
        fill_bram();
        mon_clear();
        start_cyc = cyc;
        mon_en = 1'b1;
        start = 1'b1;
        s_if.m_ready = 1'b1;
        for (int n = 0; n < 20000; n++) begin
            if (beats >= 2000) break;
            @(posedge clk); #1 start = 1'b0;
        end
        check("mid_reset_beats", beats, 2000);
        mon_en = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("mid_reset_m_valid", int'(s_if.m_valid), 0);
        check("mid_reset_busy", int'(busy), 0);
        check("mid_reset_done", int'(frame_done), 0);
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            check("post_reset_m_valid", int'(s_if.m_valid), 0);
            check("post_reset_done", int'(frame_done), 0);
        end
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
